// File: rtl/iter_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : iter_muldiv_unit
// Purpose  : Iterative multiply / divide execute unit beside the ALU.
//            MUL   : shift-add, LSB first, low WIDTH bits of product kept.
//            UDIV  : restoring division, MSB first, quotient returned.
//            SDIV  : magnitudes divided, quotient negated when signs differ.
//            Divide by zero returns 0 with unchanged latency.
//            Each operation takes WIDTH iterations plus one DONE cycle.
// Ports    : Clk, Reset_n (async, active-low)
//            Start, Op[1:0], A, B, RWIn[4:0]   - request and operands
//            Busy, Done, Result, RWOut[4:0], RegWrOut - status / write-back
// Revision : 1.0  initial release
// ============================================================================
module iter_muldiv_unit #(
  parameter int WIDTH = 64
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [4:0]       RWIn,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Result,
  output logic [4:0]       RWOut,
  output logic             RegWrOut
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] c_lastCount = CNT_W'(WIDTH - 1);
  localparam logic [1:0] c_opUdiv = 2'b01;
  localparam logic [1:0] c_opSdiv = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_nextState;

  logic [CNT_W-1:0] r_count;
  logic             r_isDiv;
  logic             r_negate;
  logic             r_divZero;
  logic [4:0]       r_rwPend;
  // MUL: r_opA = shifted multiplicand, r_opB = shifted multiplier, r_acc = product.
  // DIV: r_opA = dividend shifting out / quotient shifting in,
  //      r_opB = divisor, r_acc = partial remainder.
  logic [WIDTH-1:0] r_opA;
  logic [WIDTH-1:0] r_opB;
  logic [WIDTH-1:0] r_acc;

  logic             w_accept;
  logic             w_lastIter;
  logic             w_isSignedReq;
  logic             w_isDivReq;
  logic [WIDTH:0]   w_shifted;
  logic [WIDTH:0]   w_diff;
  logic             w_geq;
  logic [WIDTH-1:0] w_nextOpA;
  logic [WIDTH-1:0] w_nextOpB;
  logic [WIDTH-1:0] w_nextAcc;
  logic [WIDTH-1:0] w_final;

  // Start is ignored only while an operation is iterating.
  assign w_accept      = Start && (r_state != RUN);
  assign w_lastIter    = (r_state == RUN) && (r_count == c_lastCount);
  assign w_isSignedReq = (Op == c_opSdiv);
  assign w_isDivReq    = (Op == c_opUdiv) || (Op == c_opSdiv);

  // Restoring step. The remainder is always below the divisor, so the shifted
  // value is at most 2*divisor-1; the borrow bit of the (WIDTH+1)-bit
  // difference is therefore an exact "shifted < divisor" indicator.
  assign w_shifted = {r_acc, r_opA[WIDTH-1]};
  assign w_diff    = w_shifted - {1'b0, r_opB};
  assign w_geq     = ~w_diff[WIDTH];

  always_comb begin
    w_nextOpA = r_opA;
    w_nextOpB = r_opB;
    w_nextAcc = r_acc;
    w_final   = '0;
    if (r_isDiv) begin
      w_nextOpA = {r_opA[WIDTH-2:0], w_geq};
      w_nextAcc = w_geq ? w_diff[WIDTH-1:0] : w_shifted[WIDTH-1:0];
      if (!r_divZero) begin
        w_final = r_negate ? (-w_nextOpA) : w_nextOpA;
      end
    end else begin
      w_nextAcc = r_acc + (r_opB[0] ? r_opA : '0);
      w_nextOpA = r_opA << 1;
      w_nextOpB = r_opB >> 1;
      w_final   = w_nextAcc;
    end
  end

  // State register.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state and status outputs.
  always_comb begin
    w_nextState = r_state;
    Busy        = 1'b0;
    Done        = 1'b0;
    case (r_state)
      IDLE: begin
        if (Start) w_nextState = RUN;
      end
      RUN: begin
        Busy = 1'b1;
        if (w_lastIter) w_nextState = DONE;
      end
      DONE: begin
        Done        = 1'b1;
        w_nextState = Start ? RUN : IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  assign RegWrOut = Done;

  // Datapath. Result and RWOut only change on completion, so they stay stable
  // through the DONE cycle even when a back-to-back Start is accepted there.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_count   <= '0;
      r_isDiv   <= 1'b0;
      r_negate  <= 1'b0;
      r_divZero <= 1'b0;
      r_rwPend  <= '0;
      r_opA     <= '0;
      r_opB     <= '0;
      r_acc     <= '0;
      Result    <= '0;
      RWOut     <= '0;
    end else if (w_accept) begin
      r_count   <= '0;
      r_isDiv   <= w_isDivReq;
      // Magnitudes are taken here so the loop itself is always unsigned.
      // |MIN| stays 0x8000.. as an unsigned value, which yields MIN/-1 = MIN.
      r_negate  <= w_isSignedReq && (A[WIDTH-1] ^ B[WIDTH-1]);
      r_divZero <= (B == '0);
      r_rwPend  <= RWIn;
      r_opA     <= (w_isSignedReq && A[WIDTH-1]) ? (-A) : A;
      r_opB     <= (w_isSignedReq && B[WIDTH-1]) ? (-B) : B;
      r_acc     <= '0;
    end else if (r_state == RUN) begin
      r_count <= r_count + 1'b1;
      r_opA   <= w_nextOpA;
      r_opB   <= w_nextOpB;
      r_acc   <= w_nextAcc;
      if (w_lastIter) begin
        Result <= w_final;
        RWOut  <= r_rwPend;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_iter_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_iter_muldiv_unit
// Purpose  : Directed self-checking bench for iter_muldiv_unit (WIDTH=64).
// Revision : 1.0  initial release
// ============================================================================
module tb_iter_muldiv_unit;

  localparam int WIDTH = 64;
  localparam logic [1:0] OP_MUL  = 2'b00;
  localparam logic [1:0] OP_UDIV = 2'b01;
  localparam logic [1:0] OP_SDIV = 2'b10;

  logic             Clk;
  logic             Reset_n;
  logic             Start;
  logic [1:0]       Op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [4:0]       RWIn;
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] Result;
  logic [4:0]       RWOut;
  logic             RegWrOut;

  int passed = 0;
  int total  = 0;

  iter_muldiv_unit #(.WIDTH(WIDTH)) dut (
    .Clk      (Clk),
    .Reset_n  (Reset_n),
    .Start    (Start),
    .Op       (Op),
    .A        (A),
    .B        (B),
    .RWIn     (RWIn),
    .Busy     (Busy),
    .Done     (Done),
    .Result   (Result),
    .RWOut    (RWOut),
    .RegWrOut (RegWrOut)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
    end
  endtask

  // Called 1ns after an edge: presents a request, lets edge E0 take it,
  // and returns 1ns after E0 with Start released.
  task automatic startOp(input logic [1:0] op, input logic [63:0] a,
                         input logic [63:0] b, input logic [4:0] rw);
    Start = 1'b1; Op = op; A = a; B = b; RWIn = rw;
    @(posedge Clk); #1;
    Start = 1'b0; A = '0; B = '0; RWIn = '0;
  endtask

  // Counts edges until Done is seen (sampled 1ns after each edge), bounded.
  task automatic waitDone(output int n);
    n = 0;
    while (n < 100) begin
      @(posedge Clk); #1;
      n++;
      if (Done) break;
    end
  endtask

  // Full operation: latency, result, destination, one-cycle Done.
  task automatic runOp(input string tag, input logic [1:0] op, input logic [63:0] a,
                       input logic [63:0] b, input logic [4:0] rw, input logic [63:0] exp);
    int n;
    startOp(op, a, b, rw);
    waitDone(n);
    check({tag, " latency"}, 64'(n), 64'd64);
    check({tag, " result"}, Result, exp);
    check({tag, " rwout"}, 64'(RWOut), 64'(rw));
    check({tag, " regwr"}, 64'(RegWrOut), 64'd1);
    @(posedge Clk); #1;
    check({tag, " done fall"}, 64'(Done), 64'd0);
  endtask

  initial begin : main
    int  n;
    logic sawDone;
    Reset_n = 1'b0; Start = 1'b0; Op = '0; A = '0; B = '0; RWIn = '0;
    repeat (3) @(posedge Clk);
    #1;
    check("reset busy", 64'(Busy), 64'd0);
    check("reset done", 64'(Done), 64'd0);
    check("reset regwr", 64'(RegWrOut), 64'd0);
    check("reset result", Result, 64'd0);
    check("reset rwout", 64'(RWOut), 64'd0);
    @(negedge Clk); Reset_n = 1'b1;
    @(posedge Clk); #1;

    // MUL 7*6 with an explicit Busy check right after E0.
    startOp(OP_MUL, 64'd7, 64'd6, 5'd3);
    check("mul busy after E0", 64'(Busy), 64'd1);
    waitDone(n);
    check("mul latency", 64'(n), 64'd64);
    check("mul result", Result, 64'd42);
    check("mul rwout", 64'(RWOut), 64'd3);
    check("mul regwr", 64'(RegWrOut), 64'd1);
    check("mul busy in done", 64'(Busy), 64'd0);
    @(posedge Clk); #1;
    check("mul done fall", 64'(Done), 64'd0);
    check("mul regwr fall", 64'(RegWrOut), 64'd0);
    check("mul result held", Result, 64'd42);

    runOp("udiv 100/7", OP_UDIV, 64'd100, 64'd7, 5'd5, 64'd14);
    runOp("udiv max/2", OP_UDIV, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd6,
          64'h7FFF_FFFF_FFFF_FFFF);
    runOp("sdiv -100/7", OP_SDIV, -64'sd100, 64'd7, 5'd7, 64'hFFFF_FFFF_FFFF_FFF2);
    runOp("sdiv 100/-7", OP_SDIV, 64'd100, -64'sd7, 5'd8, 64'hFFFF_FFFF_FFFF_FFF2);
    runOp("sdiv -100/-7", OP_SDIV, -64'sd100, -64'sd7, 5'd9, 64'd14);
    runOp("sdiv min/-1", OP_SDIV, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
          5'd10, 64'h8000_0000_0000_0000);
    runOp("udiv 123/0", OP_UDIV, 64'd123, 64'd0, 5'd11, 64'd0);
    runOp("sdiv 123/0", OP_SDIV, 64'd123, 64'd0, 5'd12, 64'd0);
    runOp("mul reserved op", 2'b11, 64'd11, 64'd13, 5'd31, 64'd143);
    runOp("mul wrap", OP_MUL, 64'h8000_0000_0000_0001, 64'd2, 5'd13, 64'd2);

    // Start pulsed at E10 while busy must be ignored.
    startOp(OP_MUL, 64'd3, 64'd5, 5'd14);
    repeat (9) @(posedge Clk);
    #1;
    Start = 1'b1; Op = OP_MUL; A = 64'd9; B = 64'd9; RWIn = 5'd15;
    @(posedge Clk); #1;
    Start = 1'b0; A = '0; B = '0; RWIn = '0;
    check("ignored start busy", 64'(Busy), 64'd1);
    waitDone(n);
    check("ignored start latency", 64'(n + 10), 64'd64);
    check("ignored start result", Result, 64'd15);
    check("ignored start rwout", 64'(RWOut), 64'd14);

    // Back-to-back: Start held during the DONE cycle.
    startOp(OP_MUL, 64'd9, 64'd9, 5'd16);
    check("b2b result held", Result, 64'd15);
    check("b2b busy", 64'(Busy), 64'd1);
    waitDone(n);
    check("b2b latency", 64'(n + 1), 64'd65);
    check("b2b result", Result, 64'd81);
    check("b2b rwout", 64'(RWOut), 64'd16);
    @(posedge Clk); #1;

    // Asynchronous abort mid-RUN.
    startOp(OP_UDIV, 64'd1000, 64'd3, 5'd17);
    repeat (29) @(posedge Clk);
    #2;
    Reset_n = 1'b0;
    #1;
    check("abort busy", 64'(Busy), 64'd0);
    check("abort done", 64'(Done), 64'd0);
    check("abort result", Result, 64'd0);
    check("abort rwout", 64'(RWOut), 64'd0);
    @(negedge Clk); Reset_n = 1'b1;
    sawDone = 1'b0;
    for (int i = 0; i < 70; i++) begin
      @(posedge Clk); #1;
      if (Done) sawDone = 1'b1;
    end
    check("abort no done", 64'(sawDone), 64'd0);

    runOp("mul 2*2 after reset", OP_MUL, 64'd2, 64'd2, 5'd18, 64'd4);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/iter_muldiv_unit.md
# iter_muldiv_unit

Iterative multiply/divide execute unit that consumes the two 64-bit register-file read operands (BusA, BusB) and produces a 64-bit write-back value for BusW. It sits in the execute stage beside the single-cycle ALU. It handles MUL, UDIV and SDIV in a fixed WIDTH-cycle shift-add / restoring-divide loop. A Start/Busy/Done handshake lets the control unit stall issue while an operation is in flight. The destination register number travels with the operation so write-back can drive RW/RegWr on completion.

## Interface
- WIDTH, 64, operand/result width; iteration count equals WIDTH.
- Clk  input  1  clock; all state changes on posedge.
- Reset_n  input  1  asynchronous, active-low reset.
- Start  input  1  request; sampled only when Busy=0.
- Op  input  2  00=MUL (low WIDTH bits of product), 01=UDIV, 10=SDIV, 11=reserved (treated as MUL).
- A  input  WIDTH  operand from BusA (dividend / multiplicand).
- B  input  WIDTH  operand from BusB (divisor / multiplier).
- RWIn  input  5  destination register number.
- Busy  output  1  operation in flight; new Start ignored.
- Done  output  1  one-cycle completion pulse.
- Result  output  WIDTH  product/quotient; held until next completion.
- RWOut  output  5  destination captured at Start.
- RegWrOut  output  1  equals Done; drives register-file RegWr.

## Operation
- States: IDLE, RUN, DONE.
  - IDLE: Start=1 latches A, B, Op and RWIn, clears the counter, and moves to RUN.
  - RUN: one iteration per cycle. After iteration WIDTH-1, moves to DONE.
  - DONE: lasts one cycle, then returns to IDLE, or to RUN if Start=1 in that cycle.
- MUL: shift-add over B bits, LSB first. Keep only the low WIDTH bits; overflow is discarded and the operation is sign-agnostic.
- UDIV: restoring division, MSB first, with a WIDTH+1-bit partial remainder. The quotient is the result and the remainder is not output.
- SDIV:
  - Take absolute values at latch time and run UDIV.
  - Negate the quotient if the operand signs differ.
  - Truncates toward zero.
  - MIN/-1 wraps to MIN (0x8000000000000000).
- Divide by zero (UDIV or SDIV): Result=0, with no flag. The latency is unchanged.
- RWOut is passed through unmodified, including 31. Discarding writes to 31 is the register file's job.
- Busy=1 in RUN. Busy=0 in IDLE and DONE.

## Timing
- Reset (async assert, sync-safe release): state=IDLE, counter=0, Busy=0, Done=0, RegWrOut=0, Result=0, RWOut=0.
- Latency: Start accepted at edge E0. Busy rises after E0 and stays high through E(WIDTH-1).
- At E(WIDTH):
  - Busy falls.
  - Done=RegWrOut=1.
  - Result and RWOut become valid.
- At E(WIDTH+1), Done falls. Total latency is WIDTH+1 edges, i.e. Done is high for the cycle after E64 at WIDTH=64.
- Result and RWOut are stable for the whole Done-high cycle, so the negedge register-file write captures them.
- Start while Busy=1: ignored, with no queueing. Operands presented on A/B during RUN have no effect.
- Start during the DONE cycle is accepted (back-to-back). The next Done comes WIDTH+1 edges later.
- Reset_n low mid-RUN: the operation is aborted, no Done is produced, and all outputs return to reset values immediately.

## Test plan
- MUL A=7, B=6, RWIn=3 -> Done pulse after E64, Result=42, RWOut=3, RegWrOut=1 for exactly one cycle.
- UDIV A=100, B=7 -> Result=14. UDIV A=0xFFFFFFFFFFFFFFFF, B=2 -> Result=0x7FFFFFFFFFFFFFFF.
- SDIV A=-100, B=7 -> Result=0xFFFFFFFFFFFFFFF2 (-14). SDIV A=0x8000000000000000, B=-1 -> Result=0x8000000000000000.
- UDIV and SDIV with B=0, A=123 -> Result=0, Done still at E64.
- MUL 3*5 started, then Start with MUL 9*9 pulsed at E10 -> Result=15 only, single Done. A second Start held high during the Done cycle -> Result=81 after 65 more edges.
- Reset_n low at E30 of a UDIV -> Busy=0, Result=0, no Done. A new MUL 2*2 after release -> Result=4 at normal latency.
